mont_mult_cios: RTL and testbench



---
 rtl/mont_pkg.sv | 26 ++
 rtl/mont_mult_cios_mac.sv | 16 +
 rtl/mont_mult_cios.sv | 189 ++++++++++++++++++
 tb/tb_mont_mult_cios.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mont_pkg.sv
// Shared definitions for the CIOS Montgomery multiplier.
// Optional final subtraction is selected by MONT_FINAL_SUB_EN.
package mont_pkg;

  localparam int unsigned WORD_DEF  = 32;
  localparam int unsigned NW_DEF    = 32;
  localparam int unsigned WIDTH_DEF = WORD_DEF * NW_DEF;

  typedef enum logic [2:0] {
    IDLE, MUL, MUL_C, CALCM, RED, RED_C, SUB, FINAL
  } state_t;

  // Start-accept edge to the edge that raises done.
  function automatic int unsigned lat_cycles(int unsigned nw, bit sub_en);
    return sub_en ? nw * (2 * nw + 3) + nw + 1 : nw * (2 * nw + 3) + 1;
  endfunction

  localparam int unsigned LAT_SUB_EN  = lat_cycles(NW_DEF, 1'b1);
  localparam int unsigned LAT_SUB_DIS = lat_cycles(NW_DEF, 1'b0);

  // Bit offset of limb idx in a packed operand.
  function automatic int unsigned limb_lo(int unsigned idx, int unsigned word);
    return idx * word;
  endfunction

endpackage

// File: rtl/mont_mult_cios_mac.sv
// Single WORDxWORD multiply-accumulate: {hi,lo} = x*y + p + q (never overflows 2*WORD).
module mont_mac
  import mont_pkg::*;
#(
  parameter int unsigned WORD = WORD_DEF
) (
  input  logic [WORD-1:0]   x,
  input  logic [WORD-1:0]   y,
  input  logic [WORD-1:0]   p,
  input  logic [WORD-1:0]   q,
  output logic [2*WORD-1:0] s
);

  assign s = (2*WORD)'(x) * (2*WORD)'(y) + (2*WORD)'(p) + (2*WORD)'(q);

endmodule

// File: rtl/mont_mult_cios.sv
// Word-serial CIOS Montgomery multiplier: result = a*b*R^-1 mod n, R = 2^(WORD*NW).
// Macro MONT_FINAL_SUB_EN enables the final conditional subtraction (result < n).
module mont_mult_cios
  import mont_pkg::*;
#(
  parameter int unsigned WORD = WORD_DEF,
  parameter int unsigned NW   = NW_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WORD*NW-1:0]   a,
  input  logic [WORD*NW-1:0]   b,
  input  logic [WORD*NW-1:0]   n,
  input  logic [WORD-1:0]      n0prime,
  output logic [WORD*NW-1:0]   result,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned WIDTH = WORD * NW;
  localparam int unsigned AW    = $clog2(WIDTH);
  localparam int unsigned IW    = $clog2(NW + 2);

  state_t            state;
  logic [IW-1:0]     i, j;
  logic [WIDTH-1:0]  a_r, b_r, n_r;
  logic [WORD-1:0]   n0_r, c, m;
  logic [WORD-1:0]   t [NW+2];
  logic [WIDTH-1:0]  t_low;
  logic [WORD-1:0]   a_j, b_i, n_j;
  logic [WORD-1:0]   mx, my, mp, mq;
  logic [2*WORD-1:0] mac_s;
  logic [WORD-1:0]   mac_hi, mac_lo;
`ifdef MONT_FINAL_SUB_EN
  logic [WIDTH-1:0]  d;
  logic              borrow;
  logic [WORD:0]     sub;
`endif

  assign mac_hi = mac_s[2*WORD-1:WORD];
  assign mac_lo = mac_s[WORD-1:0];

  // Current operand limbs and the low NW limbs of t as a packed word.
  always_comb begin
    a_j   = a_r[AW'(limb_lo(32'(j), WORD)) +: WORD];
    b_i   = b_r[AW'(limb_lo(32'(i), WORD)) +: WORD];
    n_j   = n_r[AW'(limb_lo(32'(j), WORD)) +: WORD];
    t_low = '0;
    for (int unsigned k = 0; k < NW; k++) t_low[AW'(limb_lo(k, WORD)) +: WORD] = t[IW'(k)];
  end

  // Operand mux for the shared MAC.
  always_comb begin
    mx = '0;
    my = '0;
    mp = '0;
    mq = '0;
    case (state)
      MUL:          begin mx = a_j;  my = b_i;  mp = t[j];  mq = c; end
      MUL_C, RED_C: begin mp = t[NW]; mq = c; end
      CALCM:        begin mx = t[0]; my = n0_r; end
      RED:          begin mx = m;    my = n_j;  mp = t[j];  mq = c; end
      default:      ;
    endcase
  end

`ifdef MONT_FINAL_SUB_EN
  // Limb of t - n with incoming borrow.
  always_comb sub = {1'b0, t[j]} - {1'b0, n_j} - (WORD+1)'(borrow);
`endif

  mont_mac #(.WORD(WORD)) u_mac (
    .x(mx), .y(my), .p(mp), .q(mq), .s(mac_s)
  );

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      i      <= '0;
      j      <= '0;
      c      <= '0;
      m      <= '0;
      a_r    <= '0;
      b_r    <= '0;
      n_r    <= '0;
      n0_r   <= '0;
      for (int unsigned k = 0; k < NW + 2; k++) t[IW'(k)] <= '0;
`ifdef MONT_FINAL_SUB_EN
      d      <= '0;
      borrow <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        // The done cycle still belongs to the finishing operation, so start is not taken then.
        IDLE: if (start && !done) begin
          a_r   <= a;
          b_r   <= b;
          n_r   <= n;
          n0_r  <= n0prime;
          for (int unsigned k = 0; k < NW + 2; k++) t[IW'(k)] <= '0;
          c     <= '0;
          i     <= '0;
          j     <= '0;
          busy  <= 1'b1;
          state <= MUL;
        end
        MUL: begin
          t[j] <= mac_lo;
          c    <= mac_hi;
          if (j == IW'(NW - 1)) begin
            j     <= '0;
            state <= MUL_C;
          end else j <= j + IW'(1);
        end
        MUL_C: begin
          t[NW]   <= mac_lo;
          t[NW+1] <= mac_hi;
          state   <= CALCM;
        end
        CALCM: begin
          m     <= mac_lo;
          c     <= '0;
          state <= RED;
        end
        RED: begin
          // Low word at j=0 is zero by choice of m and is dropped (shift by one limb).
          if (j != '0) t[j - IW'(1)] <= mac_lo;
          c <= mac_hi;
          if (j == IW'(NW - 1)) begin
            j     <= '0;
            state <= RED_C;
          end else j <= j + IW'(1);
        end
        RED_C: begin
          t[NW-1] <= mac_lo;
          t[NW]   <= t[NW+1] + mac_hi;
          t[NW+1] <= '0;
          c       <= '0;
          if (i == IW'(NW - 1)) begin
            i     <= '0;
`ifdef MONT_FINAL_SUB_EN
            borrow <= 1'b0;
            state  <= SUB;
`else
            state  <= FINAL;
`endif
          end else begin
            i     <= i + IW'(1);
            state <= MUL;
          end
        end
`ifdef MONT_FINAL_SUB_EN
        SUB: begin
          d[AW'(limb_lo(32'(j), WORD)) +: WORD] <= sub[WORD-1:0];
          borrow <= sub[WORD];
          if (j == IW'(NW - 1)) begin
            j     <= '0;
            state <= FINAL;
          end else j <= j + IW'(1);
        end
        FINAL: begin
          result <= (t[NW] == WORD'(1) || !borrow) ? d : t_low;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
`else
        FINAL: begin
          result <= t_low;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
`endif
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mont_mult_cios.sv
// Directed and random checks of mont_mult_cios (default size and a 2-limb instance).
module tb_mont_mult_cios;

`ifdef MONT_FINAL_SUB_EN
  localparam int LAT = 32 * (2 * 32 + 3) + 32 + 1;
`else
  localparam int LAT = 32 * (2 * 32 + 3) + 1;
`endif

  logic          clk, reset, start;
  logic [1023:0] a, b, n, result;
  logic [31:0]   n0prime;
  logic          busy, done;

  logic          start2;
  logic [63:0]   a2, b2, n2, result2;
  logic [31:0]   n02;
  logic          busy2, done2;

  int n_vec = 0;
  int n_err = 0;

  mont_mult_cios dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .n(n),
    .n0prime(n0prime), .result(result), .busy(busy), .done(done)
  );

  mont_mult_cios #(.WORD(32), .NW(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .a(a2), .b(b2), .n(n2),
    .n0prime(n02), .result(result2), .busy(busy2), .done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got hi=%h lo=%h, expected hi=%h lo=%h",
               tag, got[1023:960], got[127:0], exp[1023:960], exp[127:0]);
    end
  endtask

  // One operation on the default-size DUT; optionally re-pulses start with other operands at cycle 50.
  task automatic op(input logic [1023:0] av, input logic [1023:0] bv, input bit poke,
                    output logic [1023:0] r, output int lat, output bit busy_ok);
    @(negedge clk);
    while (done) @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; lat = 0; busy_ok = 1'b1;
    while (!done && lat < LAT + 100) begin
      if (!busy) busy_ok = 1'b0;
      if (poke && lat == 50) begin
        a = 1024'd9; b = 1024'd11; start = 1'b1;
      end else if (poke && lat == 51) start = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    r = result;
  endtask

  task automatic op2(input logic [63:0] av, input logic [63:0] bv, input logic [63:0] nv,
                     input logic [31:0] n0v, output logic [63:0] r, output bit ok);
    int cnt;
    @(negedge clk);
    while (done2) @(negedge clk);
    a2 = av; b2 = bv; n2 = nv; n02 = n0v; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0; cnt = 0;
    while (!done2 && cnt < 200) begin
      @(posedge clk); #1;
      cnt++;
    end
    ok = done2;
    r  = result2;
  endtask

  // Reference: a*b*2^-64 mod n by 64 modular halvings.
  function automatic logic [63:0] mont_ref(input logic [63:0] av, input logic [63:0] bv,
                                           input logic [63:0] nv);
    logic [127:0] p;
    logic [64:0]  x;
    p = (128'(av) * 128'(bv)) % 128'(nv);
    x = p[64:0];
    for (int k = 0; k < 64; k++) x = x[0] ? (x + 65'(nv)) >> 1 : x >> 1;
    return x[63:0];
  endfunction

  function automatic logic [31:0] neg_inv(input logic [31:0] n0);
    logic [31:0] x;
    x = n0;
    for (int k = 0; k < 4; k++) x = x * (32'd2 - n0 * x);
    return -x;
  endfunction

  initial begin
    logic [1023:0] r, nm1, exp_big;
    logic [63:0]   rn, an, bn, nn, e2;
    logic [127:0]  ra, rb;
    int            lat, seen;
    bit            bok, ok2;

    reset = 1'b1; start = 1'b0; a = '0; b = '0;
    n = {1024{1'b1}}; n0prime = 32'd1;
    start2 = 1'b0; a2 = '0; b2 = '0; n2 = 64'd1; n02 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_result", result, '0);
    check("rst_busy", 1024'(busy), 1024'd0);
    check("rst_done", 1024'(done), 1024'd0);
    @(negedge clk); reset = 1'b0;

    op(1024'd2, 1024'd3, 1'b0, r, lat, bok);
    check("2x3", r, 1024'd6);
    check("2x3_lat", 1024'(lat), 1024'(LAT));
    check("2x3_busy", 1024'(bok), 1024'd1);
    check("2x3_busy_at_done", 1024'(busy), 1024'd0);
    // start during the done cycle is ignored
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("done_width", 1024'(done), 1024'd0);
    check("start_on_done", 1024'(busy), 1024'd0);

    nm1 = n - 1024'd1;
`ifdef MONT_FINAL_SUB_EN
    exp_big = 1024'd1;
`else
    // t ends exactly at R = n+1; without the subtraction only its low limbs (all zero) survive
    exp_big = 1024'd0;
`endif
    op(nm1, nm1, 1'b0, r, lat, bok);
    check("nm1_sq", r, exp_big);
    check("nm1_lat", 1024'(lat), 1024'(LAT));

    op(1024'd0, 1024'h1234, 1'b0, r, lat, bok);
    check("zero", r, 1024'd0);
    repeat (5) @(posedge clk);
    #1;
    check("zero_hold", result, 1024'd0);
    op(1024'd1, 1024'd1, 1'b0, r, lat, bok);
    check("one", r, 1024'd1);

    op(1024'd5, 1024'd7, 1'b1, r, lat, bok);
    check("restart_ignored", r, 1024'd35);
    check("restart_lat", 1024'(lat), 1024'(LAT));

    // reset in the middle of an operation
    @(negedge clk);
    while (done) @(negedge clk);
    a = 1024'd5; b = 1024'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (999) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_busy", 1024'(busy), 1024'd0);
    check("midrst_done", 1024'(done), 1024'd0);
    check("midrst_result", result, 1024'd0);
    seen = 0;
    repeat (LAT + 20) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    check("midrst_no_done", 1024'(seen), 1024'd0);

    // reset together with start
    @(negedge clk);
    start = 1'b1; reset = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; reset = 1'b0;
    check("rst_start_busy", 1024'(busy), 1024'd0);
    repeat (5) @(posedge clk);
    #1;
    check("rst_start_idle", 1024'({busy, done}), 1024'd0);

    // 2-limb instance against the reference model
    for (int v = 0; v < 1000; v++) begin
      nn = {$urandom, $urandom} | 64'd1;
`ifndef MONT_FINAL_SUB_EN
      nn[63:62] = 2'b00;
      if (nn == 64'd1) nn = 64'd3;
`endif
      ra = {$urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom, $urandom};
      an = 64'(ra % 128'(nn));
      bn = 64'(rb % 128'(nn));
      e2 = mont_ref(an, bn, nn);
      op2(an, bn, nn, neg_inv(nn[31:0]), rn, ok2);
      if (!ok2) check("nw2_timeout", 1024'(ok2), 1024'd1);
`ifdef MONT_FINAL_SUB_EN
      check("nw2_exact", 1024'(rn), 1024'(e2));
`else
      check("nw2_congruent", 1024'(rn % nn), 1024'(e2));
      check("nw2_below_2n", 1024'(65'(rn) < 65'(nn) * 65'd2), 1024'd1);
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
